// File: rtl/operand_streamer.sv
// Streams the stacked A/B operand image from a 1-cycle-latency memory into the
// blocked A/B order consumed by the PE array, one word per cycle.
module operand_streamer #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned A_NUM_WIDTH = 3,
    parameter int unsigned B_NUM_WIDTH = 3,
    parameter int unsigned N_MAX_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_in,
    input  logic [N_MAX_WIDTH-1:0] N_in,
    output logic                   mem_rd_en_out,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr_out,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data_in,
    output logic [DATA_WIDTH-1:0]  A_out,
    output logic                   A_valid_out,
    output logic [DATA_WIDTH-1:0]  B_out,
    output logic                   B_valid_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   err_out
);

    localparam int unsigned SI = 1 << A_NUM_WIDTH;
    localparam int unsigned SJ = 1 << B_NUM_WIDTH;
    localparam int unsigned KM = (A_NUM_WIDTH > B_NUM_WIDTH) ? A_NUM_WIDTH : B_NUM_WIDTH;
    localparam int unsigned KW = (KM > 0) ? KM : 1;
    localparam logic [KW-1:0] K_LAST_A = KW'(SI - 1);
    localparam logic [KW-1:0] K_LAST_B = KW'(SJ - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t                 state_q, state_d;
    logic [N_MAX_WIDTH-1:0] dim_q, dim_d;
    logic [N_MAX_WIDTH-1:0] i_q, i_d;   // row base of current A block (step SI)
    logic [N_MAX_WIDTH-1:0] j_q, j_d;   // column base of current B block (step SJ)
    logic [N_MAX_WIDTH-1:0] n_q, n_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   phase_b_q, phase_b_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  a_blk_q, a_blk_d;   // address of A[i][0]
    logic [ADDR_WIDTH-1:0]  b_row_q, b_row_d;   // address of B row n, column 0
    logic [ADDR_WIDTH-1:0]  nsq_q, nsq_d;       // start of the B half
    logic                   drain_q, drain_d;
    logic                   tag_vld_q, tag_vld_d;
    logic                   tag_b_q, tag_b_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic                   a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic                   done_q, done_d, err_q, err_d;

    logic [ADDR_WIDTH-1:0]  dim_a;
    logic                   start_legal;

    assign dim_a = ADDR_WIDTH'(dim_q);
    assign start_legal = (N_in != '0)
                      && ((N_in & N_MAX_WIDTH'(SI - 1)) == '0)
                      && ((N_in & N_MAX_WIDTH'(SJ - 1)) == '0);

    always_comb begin
        state_d   = state_q;
        dim_d     = dim_q;
        i_d       = i_q;
        j_d       = j_q;
        n_d       = n_q;
        k_d       = k_q;
        phase_b_d = phase_b_q;
        addr_d    = addr_q;
        a_blk_d   = a_blk_q;
        b_row_d   = b_row_q;
        nsq_d     = nsq_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    if (start_legal) begin
                        state_d   = StRun;
                        dim_d     = N_in;
                        i_d       = '0;
                        j_d       = '0;
                        n_d       = '0;
                        k_d       = '0;
                        phase_b_d = 1'b0;
                        addr_d    = '0;
                        a_blk_d   = '0;
                        // One product per run; per-word addresses are incremental.
                        nsq_d     = ADDR_WIDTH'(N_in) * ADDR_WIDTH'(N_in);
                        b_row_d   = ADDR_WIDTH'(N_in) * ADDR_WIDTH'(N_in);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (!phase_b_q && k_q != K_LAST_A) begin
                    k_d    = k_q + KW'(1);
                    addr_d = addr_q + dim_a;
                end else if (!phase_b_q) begin
                    k_d       = '0;
                    phase_b_d = 1'b1;
                    addr_d    = b_row_q + ADDR_WIDTH'(j_q);
                end else if (k_q != K_LAST_B) begin
                    k_d    = k_q + KW'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end else begin
                    k_d       = '0;
                    phase_b_d = 1'b0;
                    if (n_q != dim_q - N_MAX_WIDTH'(1)) begin
                        n_d     = n_q + N_MAX_WIDTH'(1);
                        b_row_d = b_row_q + dim_a;
                        addr_d  = a_blk_q + ADDR_WIDTH'(n_q + N_MAX_WIDTH'(1));
                    end else begin
                        n_d     = '0;
                        b_row_d = nsq_q;
                        if (j_q != dim_q - N_MAX_WIDTH'(SJ)) begin
                            j_d    = j_q + N_MAX_WIDTH'(SJ);
                            addr_d = a_blk_q;
                        end else if (i_q != dim_q - N_MAX_WIDTH'(SI)) begin
                            j_d     = '0;
                            i_d     = i_q + N_MAX_WIDTH'(SI);
                            a_blk_d = a_blk_q + (dim_a << A_NUM_WIDTH);
                            addr_d  = a_blk_q + (dim_a << A_NUM_WIDTH);
                        end else begin
                            j_d     = '0;
                            state_d = StDrain;
                            drain_d = 1'b0;
                        end
                    end
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read tag travels with the memory latency, then selects which valid fires.
    always_comb begin
        tag_vld_d = (state_q == StRun);
        tag_b_d   = phase_b_q;
        a_vld_d   = tag_vld_q && !tag_b_q;
        b_vld_d   = tag_vld_q && tag_b_q;
        a_d       = a_vld_d ? mem_rd_data_in : a_q;
        b_d       = b_vld_d ? mem_rd_data_in : b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            dim_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            phase_b_q <= 1'b0;
            addr_q    <= '0;
            a_blk_q   <= '0;
            b_row_q   <= '0;
            nsq_q     <= '0;
            drain_q   <= 1'b0;
            tag_vld_q <= 1'b0;
            tag_b_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dim_q     <= dim_d;
            i_q       <= i_d;
            j_q       <= j_d;
            n_q       <= n_d;
            k_q       <= k_d;
            phase_b_q <= phase_b_d;
            addr_q    <= addr_d;
            a_blk_q   <= a_blk_d;
            b_row_q   <= b_row_d;
            nsq_q     <= nsq_d;
            drain_q   <= drain_d;
            tag_vld_q <= tag_vld_d;
            tag_b_q   <= tag_b_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_vld_q   <= a_vld_d;
            b_vld_q   <= b_vld_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign mem_rd_en_out   = (state_q == StRun);
    assign mem_rd_addr_out = addr_q;
    assign A_out           = a_q;
    assign A_valid_out     = a_vld_q;
    assign B_out           = b_q;
    assign B_valid_out     = b_vld_q;
    assign busy_out        = (state_q != StIdle);
    assign done_out        = done_q;
    assign err_out         = err_q;

endmodule

// File: tb/tb_operand_streamer.sv
// Directed bench for operand_streamer: memory model, stream order, timing,
// illegal N, held start, and mid-run reset.
module tb_operand_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] N_in = '0;
    logic        mem_rd_en_out;
    logic [31:0] mem_rd_addr_out;
    logic [63:0] mem_rd_data_in = '0;
    logic [63:0] A_out, B_out;
    logic        A_valid_out, B_valid_out, busy_out, done_out, err_out;

    operand_streamer dut (
        .clk             (clk),
        .rst             (rst),
        .start_in        (start_in),
        .N_in            (N_in),
        .mem_rd_en_out   (mem_rd_en_out),
        .mem_rd_addr_out (mem_rd_addr_out),
        .mem_rd_data_in  (mem_rd_data_in),
        .A_out           (A_out),
        .A_valid_out     (A_valid_out),
        .B_out           (B_out),
        .B_valid_out     (B_valid_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .err_out         (err_out)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int unsigned cur_n = 16;

    logic [63:0] obs_d[$];
    bit          obs_b[$];
    int          obs_c[$];
    int unsigned rd_addrs[$];
    int          rd_cnt, done_cnt, err_cnt, busy_cnt, done_cyc;
    bit          done_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_at(input int unsigned addr, input int unsigned n);
        int unsigned r, c;
        if (n == 0) return 64'd0;
        r = addr / n;
        c = addr % n;
        if (r < n) return 64'h1000 + 64'(r * 16 + c);
        return 64'h2000 + 64'((r - n) * 16 + c);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (mem_rd_en_out) mem_rd_data_in <= word_at(mem_rd_addr_out, cur_n);
    end

    always @(negedge clk) begin
        check("valid_excl", 64'(A_valid_out & B_valid_out), 64'd0);
        if (A_valid_out) begin
            obs_d.push_back(A_out); obs_b.push_back(1'b0); obs_c.push_back(cyc);
        end
        if (B_valid_out) begin
            obs_d.push_back(B_out); obs_b.push_back(1'b1); obs_c.push_back(cyc);
        end
        if (mem_rd_en_out) begin
            rd_cnt++;
            rd_addrs.push_back(mem_rd_addr_out);
        end
        if (done_out) begin
            done_cnt++; done_seen = 1'b1; done_cyc = cyc;
        end
        if (err_out) err_cnt++;
        if (busy_out) busy_cnt++;
    end

    task automatic clear_obs();
        obs_d.delete(); obs_b.delete(); obs_c.delete(); rd_addrs.delete();
        rd_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; done_cyc = 0;
        done_seen = 1'b0;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_rd_en"}, 64'(mem_rd_en_out), 64'd0);
        check({pfx, "_addr"}, 64'(mem_rd_addr_out), 64'd0);
        check({pfx, "_A_out"}, A_out, 64'd0);
        check({pfx, "_B_out"}, B_out, 64'd0);
        check({pfx, "_A_valid"}, 64'(A_valid_out), 64'd0);
        check({pfx, "_B_valid"}, 64'(B_valid_out), 64'd0);
        check({pfx, "_busy"}, 64'(busy_out), 64'd0);
        check({pfx, "_done"}, 64'(done_out), 64'd0);
        check({pfx, "_err"}, 64'(err_out), 64'd0);
    endtask

    // Pulses start for one cycle; returns the monitor cycle index of the first read cycle.
    task automatic start_run(input int unsigned n, output int s1);
        @(negedge clk);
        clear_obs();
        cur_n = n;
        N_in = n;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        N_in = 32'd24;
        s1 = cyc;
        check("start_busy", 64'(busy_out), 64'd1);
        check("start_rd_en", 64'(mem_rd_en_out), 64'd1);
        check("start_addr", 64'(mem_rd_addr_out), 64'd0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done_seen && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("done_seen", 64'(done_seen), 64'd1);
    endtask

    task automatic check_stream(input int n, input int s1);
        logic [63:0] ed[$];
        bit          eb[$];
        int          m;
        for (int i = 0; i < n / 8; i++)
            for (int j = 0; j < n / 8; j++)
                for (int nn = 0; nn < n; nn++) begin
                    for (int ii = 0; ii < 8; ii++) begin
                        ed.push_back(64'h1000 + 64'((i * 8 + ii) * 16 + nn));
                        eb.push_back(1'b0);
                    end
                    for (int jj = 0; jj < 8; jj++) begin
                        ed.push_back(64'h2000 + 64'(nn * 16 + j * 8 + jj));
                        eb.push_back(1'b1);
                    end
                end
        check("word_count", 64'(obs_d.size()), 64'(ed.size()));
        m = (obs_d.size() < ed.size()) ? obs_d.size() : ed.size();
        for (int k = 0; k < m; k++) begin
            check($sformatf("data[%0d]", k), obs_d[k], ed[k]);
            check($sformatf("phase[%0d]", k), 64'(obs_b[k]), 64'(eb[k]));
        end
        if (obs_c.size() > 0) begin
            check("first_valid_cycle", 64'(obs_c[0]), 64'(s1 + 2));
            check("done_after_last", 64'(done_cyc), 64'(obs_c[obs_c.size() - 1] + 1));
        end else begin
            check("any_valid", 64'd0, 64'd1);
        end
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("read_count", 64'(rd_cnt), 64'(ed.size()));
        check("busy_cycles", 64'(busy_cnt), 64'(ed.size() + 2));
    endtask

    initial begin
        int s1;
        int hits[128];
        int k;
        clear_obs();
        repeat (3) @(negedge clk);
        check_outputs_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset");

        // N=16 full stream
        start_run(16, s1);
        wait_done(2000);
        check_stream(16, s1);
        check("word0_A00", obs_d[0], 64'h1000);
        check("word8_B00", obs_d[8], 64'h2000);
        check("last_B1515", obs_d[1023], 64'h20ff);

        // N=8 single block, every address read once
        start_run(8, s1);
        wait_done(600);
        check_stream(8, s1);
        for (int a = 0; a < 128; a++) hits[a] = 0;
        foreach (rd_addrs[x]) if (rd_addrs[x] < 128) hits[rd_addrs[x]]++;
        for (int a = 0; a < 128; a++) check($sformatf("addr_hit[%0d]", a), 64'(hits[a]), 64'd1);

        // Illegal N values
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            clear_obs();
            N_in = (t == 0) ? 32'd0 : 32'd12;
            start_in = 1'b1;
            @(negedge clk);
            start_in = 1'b0;
            check($sformatf("err_pulse_%0d", t), 64'(err_out), 64'd1);
            check($sformatf("err_busy_%0d", t), 64'(busy_out), 64'd0);
            repeat (4) @(negedge clk);
            check($sformatf("err_count_%0d", t), 64'(err_cnt), 64'd1);
            check($sformatf("err_reads_%0d", t), 64'(rd_cnt), 64'd0);
            check($sformatf("err_busy_cycles_%0d", t), 64'(busy_cnt), 64'd0);
        end

        // start held high: one stream, next begins right after done
        @(negedge clk);
        clear_obs();
        cur_n = 8;
        N_in = 32'd8;
        start_in = 1'b1;
        @(negedge clk);
        s1 = cyc;
        wait_done(600);
        check_stream(8, s1);
        clear_obs();
        @(negedge clk);
        s1 = cyc;
        check("b2b_rd_en", 64'(mem_rd_en_out), 64'd1);
        check("b2b_addr", 64'(mem_rd_addr_out), 64'd0);
        check("b2b_busy", 64'(busy_out), 64'd1);
        start_in = 1'b0;
        wait_done(600);
        check_stream(8, s1);

        // Reset at word 300 of an N=16 run
        start_run(16, s1);
        k = 0;
        while (obs_d.size() < 300 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        check("reached_word300", 64'(obs_d.size() >= 300), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt), 64'd0);
        check("idle_after_reset", 64'(busy_out), 64'd0);
        start_run(16, s1);
        wait_done(2000);
        check_stream(16, s1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
